// File: rtl/sap_seq_ctrl.sv
// rtl/sap_seq_ctrl.sv - SAP-class control sequencer with T-state ring, decode, step mode and retire counter
module sap_seq_ctrl #(
  parameter int OPC_W = 4,
  parameter int ALU_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero_flag,
  input  logic             carry_flag,
  input  logic             step_mode,
  input  logic             step,
  output logic [5:0]       t_state,
  output logic             cp,
  output logic             mar_load,
  output logic             mar_sel,
  output logic             chip_enable,
  output logic             w_enable,
  output logic             ir_load,
  output logic             A_load,
  output logic             B_load,
  output logic             out_load,
  output logic             opnd_to_a,
  output logic             pc_load,
  output logic             flags_load,
  output logic [ALU_W-1:0] alu_op,
  output logic             halt,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] T0 = 6'b000001;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_NOP = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic       hold;
  logic       op_illegal;
  logic [3:0] op;
  logic       stall;
  logic       active;
  logic [5:0] t_next;

  // Any set bit above the 4-bit opcode field makes it illegal; it then decodes as NOP.
  assign op_illegal = |(opcode >> 4);
  assign op         = op_illegal ? OP_NOP : opcode[3:0];

  // Hold only matters in step mode; leaving step mode lets T0 run at once.
  assign stall  = hold & step_mode & t_state[0];
  assign active = rst_n & ~halt & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_state <= T0;
    end else begin
      t_state <= t_next;
    end
  end

  always_comb begin
    t_next = {t_state[4:0], 1'b0};
    if (!active || instr_done || t_state[5]) begin
      t_next = T0;
    end
  end

  always_comb begin
    cp          = 1'b0;
    mar_load    = 1'b0;
    mar_sel     = 1'b0;
    chip_enable = 1'b0;
    w_enable    = 1'b0;
    ir_load     = 1'b0;
    A_load      = 1'b0;
    B_load      = 1'b0;
    out_load    = 1'b0;
    opnd_to_a   = 1'b0;
    pc_load     = 1'b0;
    flags_load  = 1'b0;
    alu_op      = '0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    if (active) begin
      if (t_state[0]) mar_load = 1'b1;
      if (t_state[1]) cp = 1'b1;
      if (t_state[2]) begin
        chip_enable = 1'b1;
        ir_load     = 1'b1;
      end
      if (t_state[3]) begin
        illegal = op_illegal;
        case (op)
          OP_LDA, OP_SUB, OP_ADD, OP_STA: begin
            mar_sel  = 1'b1;
            mar_load = 1'b1;
          end
          OP_LDI: begin
            opnd_to_a  = 1'b1;
            A_load     = 1'b1;
            instr_done = 1'b1;
          end
          OP_JMP: begin
            pc_load    = 1'b1;
            instr_done = 1'b1;
          end
          OP_JZ: begin
            pc_load    = zero_flag;
            instr_done = 1'b1;
          end
          OP_JC: begin
            pc_load    = carry_flag;
            instr_done = 1'b1;
          end
          OP_OUT: begin
            out_load   = 1'b1;
            instr_done = 1'b1;
          end
          default: instr_done = 1'b1;
        endcase
      end
      if (t_state[4]) begin
        chip_enable = 1'b1;
        if (op == OP_STA) begin
          w_enable   = 1'b1;
          instr_done = 1'b1;
        end else begin
          B_load = 1'b1;
        end
      end
      if (t_state[5]) begin
        A_load     = 1'b1;
        instr_done = 1'b1;
        if (op == OP_ADD) begin
          alu_op     = ALU_W'(1);
          flags_load = 1'b1;
        end else if (op == OP_SUB) begin
          alu_op     = ALU_W'(2);
          flags_load = 1'b1;
        end
      end
    end
  end

  // instr_done is already gated by halt, so the counter freezes once halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt        <= 1'b0;
      hold        <= 1'b1;
      instr_count <= '0;
    end else begin
      if (instr_done) begin
        instr_count <= instr_count + CNT_W'(1);
      end
      if (instr_done && t_state[3] && op == OP_HLT) begin
        halt <= 1'b1;
      end
      if (!step_mode) begin
        hold <= 1'b0;
      end else if (instr_done) begin
        hold <= 1'b1;
      end else if (stall && step && !halt) begin
        hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sap_seq_ctrl.sv
// tb/tb_sap_seq_ctrl.sv - scoreboard bench for sap_seq_ctrl
module tb_sap_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero_flag, carry_flag, step_mode, step;
  logic [5:0] t_state;
  logic       cp, mar_load, mar_sel, chip_enable, w_enable, ir_load;
  logic       A_load, B_load, out_load, opnd_to_a, pc_load, flags_load;
  logic [3:0] alu_op;
  logic       halt, instr_done, illegal;
  logic [3:0] instr_count;

  sap_seq_ctrl #(.OPC_W(6), .ALU_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .step_mode(step_mode), .step(step),
    .t_state(t_state), .cp(cp), .mar_load(mar_load), .mar_sel(mar_sel),
    .chip_enable(chip_enable), .w_enable(w_enable), .ir_load(ir_load),
    .A_load(A_load), .B_load(B_load), .out_load(out_load),
    .opnd_to_a(opnd_to_a), .pc_load(pc_load), .flags_load(flags_load),
    .alu_op(alu_op), .halt(halt), .instr_done(instr_done),
    .illegal(illegal), .instr_count(instr_count)
  );

  typedef struct {
    logic [5:0]  op;
    logic        z, c, stp, smode, hlt;
    logic [5:0]  ts;
    logic [13:0] sb;
    logic [3:0]  alu;
  } ent_t;

  ent_t sb_q[$];
  ent_t e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sb bits: 13 cp,12 mar_load,11 mar_sel,10 ce,9 we,8 ir,7 A,6 B,5 out,4 opnd,3 pc,2 flags,1 done,0 illegal
  function automatic logic [13:0] obs();
    return {cp, mar_load, mar_sel, chip_enable, w_enable, ir_load, A_load, B_load,
            out_load, opnd_to_a, pc_load, flags_load, instr_done, illegal};
  endfunction

  task automatic push_instr(input logic [5:0] op, input logic z, input logic c,
                            input logic smode, input int stp_t);
    logic       ill;
    logic [3:0] lo;
    ill = |op[5:4];
    lo  = op[3:0];
    for (int t = 0; t < 6; t++) begin
      ent_t n;
      n.op = op; n.z = z; n.c = c; n.smode = smode; n.stp = (t == stp_t);
      n.hlt = 1'b0; n.ts = 6'(1) << t; n.sb = '0; n.alu = '0;
      case (t)
        0: n.sb[12] = 1'b1;
        1: n.sb[13] = 1'b1;
        2: begin n.sb[10] = 1'b1; n.sb[8] = 1'b1; end
        3: if (ill) n.sb[1:0] = 2'b11;
           else case (lo)
             4'h0, 4'h1, 4'h2, 4'h3: n.sb[12:11] = 2'b11;
             4'h4: begin n.sb[7] = 1'b1; n.sb[4] = 1'b1; n.sb[1] = 1'b1; end
             4'h5: begin n.sb[3] = 1'b1; n.sb[1] = 1'b1; end
             4'h6: begin n.sb[3] = z; n.sb[1] = 1'b1; end
             4'h7: begin n.sb[3] = c; n.sb[1] = 1'b1; end
             4'hE: begin n.sb[5] = 1'b1; n.sb[1] = 1'b1; end
             default: n.sb[1] = 1'b1;
           endcase
        4: if (lo == 4'h3) begin n.sb[10] = 1'b1; n.sb[9] = 1'b1; n.sb[1] = 1'b1; end
           else begin n.sb[10] = 1'b1; n.sb[6] = 1'b1; end
        default: begin
          n.sb[7] = 1'b1; n.sb[1] = 1'b1;
          if (lo == 4'h2) begin n.alu = 4'd1; n.sb[2] = 1'b1; end
          else if (lo == 4'h1) begin n.alu = 4'd2; n.sb[2] = 1'b1; end
        end
      endcase
      sb_q.push_back(n);
      if (n.sb[1]) break;
    end
  endtask

  task automatic push_idle(input int cnt, input logic stp, input logic smode, input logic hlt);
    for (int i = 0; i < cnt; i++) begin
      ent_t n;
      n.op = 6'h10; n.z = 1'b1; n.c = 1'b1; n.stp = stp; n.smode = smode; n.hlt = hlt;
      n.ts = 6'b000001; n.sb = '0; n.alu = '0;
      sb_q.push_back(n);
    end
  endtask

  task automatic do_reset(input logic smode);
    step_mode = smode;
    step = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step_mode = 1'b0; step = 1'b0; opcode = 6'h02;
    zero_flag = 1'b0; carry_flag = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({t_state, obs(), alu_op, halt, instr_count} !== {6'b000001, 14'h0, 4'h0, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset: got ts=%b sb=%b alu=%0d halt=%b cnt=%0d, want ts=000001 all zero",
               t_state, obs(), alu_op, halt, instr_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    push_instr(6'h00, 0, 0, 0, -1);
    push_instr(6'h02, 0, 0, 0, -1);
    push_instr(6'h0E, 0, 0, 0, -1);
    push_instr(6'h0F, 0, 0, 0, -1);
    push_idle(3, 1'b1, 1'b0, 1'b1);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero_flag = e.z; carry_flag = e.c; step = e.stp; step_mode = e.smode;
      @(negedge clk);
      cyc++; n_chk++;
      if ({t_state, obs(), alu_op, halt} !== {e.ts, e.sb, e.alu, e.hlt}) begin
        n_fail++;
        $display("FAIL free_run cyc %0d: got ts=%b sb=%b alu=%0d halt=%b, want ts=%b sb=%b alu=%0d halt=%b",
                 cyc, t_state, obs(), alu_op, halt, e.ts, e.sb, e.alu, e.hlt);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (instr_count !== 4'd4) begin
      n_fail++;
      $display("FAIL free_run count: got %0d want 4", instr_count);
    end
  endtask

  task automatic test_jumps();
    do_reset(1'b0);
    push_instr(6'h06, 0, 1, 0, -1);
    push_instr(6'h06, 1, 0, 0, -1);
    push_instr(6'h07, 1, 0, 0, -1);
    push_instr(6'h07, 0, 1, 0, -1);
    push_instr(6'h05, 0, 0, 0, -1);
    push_instr(6'h04, 0, 0, 0, -1);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero_flag = e.z; carry_flag = e.c; step = e.stp; step_mode = e.smode;
      @(negedge clk);
      cyc++; n_chk++;
      if ({t_state, obs(), alu_op, halt} !== {e.ts, e.sb, e.alu, e.hlt}) begin
        n_fail++;
        $display("FAIL jumps cyc %0d: got ts=%b sb=%b alu=%0d halt=%b, want ts=%b sb=%b alu=%0d halt=%b",
                 cyc, t_state, obs(), alu_op, halt, e.ts, e.sb, e.alu, e.hlt);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (instr_count !== 4'd6) begin
      n_fail++;
      $display("FAIL jumps count: got %0d want 6", instr_count);
    end
  endtask

  task automatic test_sta();
    do_reset(1'b0);
    push_instr(6'h03, 0, 0, 0, -1);
    push_instr(6'h08, 0, 0, 0, -1);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero_flag = e.z; carry_flag = e.c; step = e.stp; step_mode = e.smode;
      @(negedge clk);
      cyc++; n_chk++;
      if ({t_state, obs(), alu_op, halt} !== {e.ts, e.sb, e.alu, e.hlt}) begin
        n_fail++;
        $display("FAIL sta cyc %0d: got ts=%b sb=%b alu=%0d halt=%b, want ts=%b sb=%b alu=%0d halt=%b",
                 cyc, t_state, obs(), alu_op, halt, e.ts, e.sb, e.alu, e.hlt);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (instr_count !== 4'd2) begin
      n_fail++;
      $display("FAIL sta count: got %0d want 2", instr_count);
    end
  endtask

  task automatic test_step();
    do_reset(1'b1);
    push_idle(2, 1'b0, 1'b1, 1'b0);
    push_idle(1, 1'b1, 1'b1, 1'b0);
    push_instr(6'h08, 0, 0, 1, 1);
    push_idle(4, 1'b0, 1'b1, 1'b0);
    push_idle(1, 1'b1, 1'b1, 1'b0);
    push_instr(6'h08, 0, 0, 1, -1);
    push_idle(2, 1'b0, 1'b1, 1'b0);
    push_instr(6'h04, 0, 0, 0, -1);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero_flag = e.z; carry_flag = e.c; step = e.stp; step_mode = e.smode;
      @(negedge clk);
      cyc++; n_chk++;
      if ({t_state, obs(), alu_op, halt} !== {e.ts, e.sb, e.alu, e.hlt}) begin
        n_fail++;
        $display("FAIL step cyc %0d: got ts=%b sb=%b alu=%0d halt=%b, want ts=%b sb=%b alu=%0d halt=%b",
                 cyc, t_state, obs(), alu_op, halt, e.ts, e.sb, e.alu, e.hlt);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (instr_count !== 4'd3) begin
      n_fail++;
      $display("FAIL step count: got %0d want 3", instr_count);
    end
  endtask

  task automatic test_illegal();
    do_reset(1'b0);
    push_instr(6'b010010, 0, 0, 0, -1);
    push_instr(6'b100000, 0, 0, 0, -1);
    push_instr(6'h00, 0, 0, 0, -1);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero_flag = e.z; carry_flag = e.c; step = e.stp; step_mode = e.smode;
      @(negedge clk);
      cyc++; n_chk++;
      if ({t_state, obs(), alu_op, halt} !== {e.ts, e.sb, e.alu, e.hlt}) begin
        n_fail++;
        $display("FAIL illegal cyc %0d: got ts=%b sb=%b alu=%0d halt=%b, want ts=%b sb=%b alu=%0d halt=%b",
                 cyc, t_state, obs(), alu_op, halt, e.ts, e.sb, e.alu, e.hlt);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (instr_count !== 4'd3) begin
      n_fail++;
      $display("FAIL illegal count: got %0d want 3", instr_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    push_instr(6'h04, 0, 0, 0, -1);
    push_instr(6'h02, 0, 0, 0, -1);
    void'(sb_q.pop_back());
    void'(sb_q.pop_back());
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero_flag = e.z; carry_flag = e.c; step = e.stp; step_mode = e.smode;
      @(negedge clk);
      cyc++; n_chk++;
      if ({t_state, obs(), alu_op, halt} !== {e.ts, e.sb, e.alu, e.hlt}) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got ts=%b sb=%b alu=%0d halt=%b, want ts=%b sb=%b alu=%0d halt=%b",
                 cyc, t_state, obs(), alu_op, halt, e.ts, e.sb, e.alu, e.hlt);
      end
      @(posedge clk); #1;
    end
    #1;
    n_chk++;
    if ({t_state, B_load, instr_count} !== {6'b010000, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL reset_mid pre: got ts=%b B_load=%b cnt=%0d, want ts=010000 B_load=1 cnt=1",
               t_state, B_load, instr_count);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({t_state, obs(), instr_count} !== {6'b000001, 14'h0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_mid abort: got ts=%b sb=%b cnt=%0d, want ts=000001 sb=0 cnt=0",
               t_state, obs(), instr_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_instr(6'h00, 0, 0, 0, -1);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero_flag = e.z; carry_flag = e.c; step = e.stp; step_mode = e.smode;
      @(negedge clk);
      cyc++; n_chk++;
      if ({t_state, obs(), alu_op, halt} !== {e.ts, e.sb, e.alu, e.hlt}) begin
        n_fail++;
        $display("FAIL reset_mid refetch cyc %0d: got ts=%b sb=%b alu=%0d, want ts=%b sb=%b alu=%0d",
                 cyc, t_state, obs(), alu_op, e.ts, e.sb, e.alu);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) begin
      push_instr((i % 2 == 0) ? 6'h04 : 6'h0E, 0, 0, 0, -1);
    end
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      opcode = e.op; zero_flag = e.z; carry_flag = e.c; step = e.stp; step_mode = e.smode;
      @(negedge clk);
      cyc++; n_chk++;
      if ({t_state, obs(), alu_op, halt} !== {e.ts, e.sb, e.alu, e.hlt}) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got ts=%b sb=%b alu=%0d halt=%b, want ts=%b sb=%b alu=%0d halt=%b",
                 cyc, t_state, obs(), alu_op, halt, e.ts, e.sb, e.alu, e.hlt);
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (instr_count !== 4'd1) begin
      n_fail++;
      $display("FAIL back_to_back wrap count: got %0d want 1", instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_jumps();
    test_sta();
    test_step();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_seq_ctrl.md
# sap_seq_ctrl

Parametrised SAP-class control sequencer: next generation of the SAP-1 control unit. Owns its own one-hot T-state ring counter and decodes the instruction register into the per-cycle control word. Adds immediate load, unconditional and flag-conditional jumps, variable-length instructions with early ring reset, instruction-level single-step mode, illegal-opcode detection and a retired-instruction counter. Sits between the IR/flag register and the PC, MAR, RAM, A, B, ALU and output registers.

## Interface
- OPC_W, 4: opcode width, 4..8. Bits above [3] must be zero for a legal opcode.
- ALU_W, 4: alu_op width, ≥2.
- CNT_W, 16: retired-instruction counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPC_W  IR opcode field; valid from T3 onward.
- zero_flag  in  1  registered Z flag.
- carry_flag  in  1  registered C flag.
- step_mode  in  1  1 = single-step, 0 = free-run.
- step  in  1  one-cycle request to start the next instruction in step mode.
- t_state  out  6  one-hot ring state, T0 = 6'b000001.
- cp, mar_load, mar_sel, chip_enable, w_enable, ir_load, A_load, B_load, out_load  out  1 each  datapath strobes.
- opnd_to_a  out  1  selects IR operand onto the A input (LDI).
- pc_load  out  1  loads PC from IR operand.
- flags_load  out  1  captures ALU Z/C into the flag register.
- alu_op  out  ALU_W  0 = pass B, 1 = add, 2 = sub.
- halt  out  1  latched halt.
- instr_done  out  1  high during the last state of every instruction.
- illegal  out  1  high at T3 when the opcode is illegal.
- instr_count  out  CNT_W  retired instructions.

## Operation
- Opcode map (low 4 bits): 0000 LDA, 0001 SUB, 0010 ADD, 0011 STA, 0100 LDI, 0101 JMP, 0110 JZ, 0111 JC, 1110 OUT, 1111 HLT. Unlisted codes are NOP.
- Any nonzero bit above [3] makes the opcode illegal. An illegal opcode executes as NOP and pulses `illegal`.
- Fetch, same for all instructions:
  - T0: mar_load (mar_sel=0).
  - T1: cp.
  - T2: chip_enable, ir_load.
- T3:
  - LDA/ADD/SUB/STA: mar_sel=1, mar_load.
  - LDI: opnd_to_a, A_load, done.
  - JMP: pc_load, done.
  - JZ: pc_load only if zero_flag=1, done.
  - JC: pc_load only if carry_flag=1, done.
  - OUT: out_load, done.
  - NOP/illegal: done.
  - HLT: done; halt sets at the T3 edge.
- T4:
  - LDA/ADD/SUB: chip_enable, B_load.
  - STA: chip_enable, w_enable, done.
- T5, always done:
  - LDA: alu_op=0, A_load.
  - ADD: alu_op=1, A_load, flags_load.
  - SUB: alu_op=2, A_load, flags_load.
- Done state:
  - `instr_done`=1.
  - Ring returns to T0 at the next edge.
  - instr_count increments at that edge, wrapping at 2^CNT_W. HLT counts.
- Outputs are combinational from t_state, opcode and flags. Every unlisted strobe is 0, alu_op is 0.
- Step mode uses an internal `hold` bit:
  - hold sets at a done edge when step_mode=1.
  - While hold=1 and the ring is in T0, all strobes are 0 and the ring does not advance.
  - step=1 in that condition clears hold at the edge; T0 then executes in the following cycle.
  - step_mode=0 clears hold at the next edge.
  - step outside a hold state is ignored.
- Halt:
  - Ring is forced to T0; all strobes are 0; counter is frozen; step is ignored.
  - Cleared only by rst_n.

## Timing
- Reset values (rst_n low, asynchronous):
  - t_state=6'b000001, halt=0, hold=1, instr_count=0.
  - All strobes, instr_done and illegal are 0.
- First active cycle after reset release:
  - step_mode=0: T0 fetch proceeds immediately (hold is ignored).
  - step_mode=1: the sequencer waits for step.
- Instruction length:
  - 4 cycles: LDI, JMP, JZ, JC, OUT, NOP, HLT.
  - 5 cycles: STA.
  - 6 cycles: LDA, ADD, SUB.
- The ring advances exactly one state per cycle when not held or halted.
- Reset mid-instruction aborts immediately. No partial write is completed after rst_n falls.
- Flags are sampled at T3 of the jump. A flags_load in the preceding instruction's T5 is visible.

## Test plan
- Free-run, IR sequence LDA, ADD, OUT, HLT -> 6+6+4+4 cycles. ADD T5 shows alu_op=1, A_load=1, flags_load=1. halt=1 after the 20th cycle. instr_count=4 and holds.
- JZ with zero_flag=0, then again with zero_flag=1 -> pc_load=0 in the first T3, pc_load=1 in the second. Both instructions last 4 cycles with instr_done at T3.
- STA -> T4 has chip_enable=1 and w_enable=1. The ring is back at T0 on cycle 6. No A_load in any cycle.
- Step mode, two NOPs, step pulses at cycles 3 and 12 -> no strobes before cycle 4. The first NOP runs cycles 4–7; idle at T0 until the second step.
- OPC_W=6, opcode 6'b010010 -> illegal=1 at T3, no A_load/B_load, 4-cycle instruction, instr_count+1.
- rst_n low during T4 of ADD -> B_load drops immediately, t_state=000001, instr_count=0. The instruction fetch restarts after release.
